// File: rtl/z80_mem_bridge.sv
// z80_mem_bridge: tv80n CPU bus to block-RAM ROM/RAM bridge.
// Issues one registered enable pulse per access and stalls reads with wait states
// to cover block-RAM latency.
// Optional IM2 vblank interrupt source: define Z80_MEM_BRIDGE_IM2_EN.
module z80_mem_bridge #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ROM_AW      = 14,
    parameter int unsigned RAM_AW      = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cpu_A,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_mreq_n,
    input  logic              cpu_iorq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic              cpu_m1_n,
    output logic [7:0]        cpu_di,
    output logic              cpu_wait_n,
    output logic              cpu_int_n,
    input  logic              vblank,
    output logic [ROM_AW-1:0] rom_addra,
    output logic              rom_ena,
    input  logic [7:0]        rom_douta,
    output logic [RAM_AW-1:0] ram_addra,
    output logic [7:0]        ram_dina,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [RAM_AW-1:0] ram_addrb,
    output logic              ram_enb,
    input  logic [7:0]        ram_doutb
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              tgt_ram_q, tgt_ram_d;
    logic              hold_io_q, hold_io_d;   // HOLD waits on iorq rather than mem strobes
    logic [7:0]        cpu_di_q, cpu_di_d;
    logic              wait_n_q, wait_n_d;
    logic [ROM_AW-1:0] rom_addra_q, rom_addra_d;
    logic              rom_ena_q, rom_ena_d;
    logic [RAM_AW-1:0] ram_addra_q, ram_addra_d;
    logic [7:0]        ram_dina_q, ram_dina_d;
    logic              ram_ena_q, ram_ena_d;
    logic              ram_wea_q, ram_wea_d;
    logic [RAM_AW-1:0] ram_addrb_q, ram_addrb_d;
    logic              ram_enb_q, ram_enb_d;

    logic mem_rd, mem_wr, int_ack;
    assign mem_rd  = !cpu_mreq_n && !cpu_rd_n;
    assign mem_wr  = !cpu_mreq_n && !cpu_wr_n;
    assign int_ack = !cpu_m1_n && !cpu_iorq_n;

    // Only some address bits feed the decode and memory ports.
    logic unused_bits;

`ifdef Z80_MEM_BRIDGE_IM2_EN
    logic [7:0] vec_q, vec_d;
    logic       irq_en_q, irq_en_d;
    logic       pending_q, pending_d;
    logic       vblank_q;
    logic       ack_clr;
    logic       io_wr;
    assign io_wr       = !cpu_iorq_n && !cpu_wr_n && cpu_m1_n;
    assign cpu_int_n   = !(pending_q && irq_en_q);
    assign unused_bits = ^cpu_A;
    // A vblank edge in the acknowledge cycle wins over the clear.
    assign pending_d   = (vblank && !vblank_q) || (pending_q && !ack_clr);
`else
    assign cpu_int_n   = 1'b1;
    assign unused_bits = ^{cpu_A, vblank};
`endif

    // Bus decode and access sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_ram_d   = tgt_ram_q;
        hold_io_d   = hold_io_q;
        cpu_di_d    = cpu_di_q;
        wait_n_d    = wait_n_q;
        rom_addra_d = rom_addra_q;
        rom_ena_d   = 1'b0;
        ram_addra_d = ram_addra_q;
        ram_dina_d  = ram_dina_q;
        ram_ena_d   = 1'b0;
        ram_wea_d   = 1'b0;
        ram_addrb_d = ram_addrb_q;
        ram_enb_d   = 1'b0;
`ifdef Z80_MEM_BRIDGE_IM2_EN
        vec_d       = vec_q;
        irq_en_d    = irq_en_q;
        ack_clr     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (int_ack) begin
`ifdef Z80_MEM_BRIDGE_IM2_EN
                    cpu_di_d = vec_q;
                    ack_clr  = 1'b1;
`else
                    cpu_di_d = 8'hFF;
`endif
                    hold_io_d = 1'b1;
                    state_d   = StHold;
`ifdef Z80_MEM_BRIDGE_IM2_EN
                end else if (io_wr) begin
                    if (cpu_A[7:0] == 8'h00) begin
                        vec_d = cpu_dout;
                    end else if (cpu_A[7:0] == 8'h01) begin
                        irq_en_d = cpu_dout[0];
                    end
                    hold_io_d = 1'b1;
                    state_d   = StHold;
`endif
                end else if (mem_rd) begin
                    // Read wins over a simultaneous write strobe.
                    tgt_ram_d = cpu_A[15];
                    if (cpu_A[15]) begin
                        ram_addrb_d = cpu_A[RAM_AW-1:0];
                        ram_enb_d   = 1'b1;
                    end else begin
                        rom_addra_d = cpu_A[ROM_AW-1:0];
                        rom_ena_d   = 1'b1;
                    end
                    wait_n_d  = 1'b0;
                    hold_io_d = 1'b0;
                    state_d   = StAccess;
                end else if (mem_wr) begin
                    // ROM writes are dropped without a pulse.
                    if (cpu_A[15]) begin
                        ram_addra_d = cpu_A[RAM_AW-1:0];
                        ram_dina_d  = cpu_dout;
                        ram_ena_d   = 1'b1;
                        ram_wea_d   = 1'b1;
                    end
                    hold_io_d = 1'b0;
                    state_d   = StHold;
                end
            end
            StAccess: begin
                if (!mem_rd) begin
                    wait_n_d = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d   = 3'(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!mem_rd) begin
                    wait_n_d = 1'b1;
                    state_d  = StIdle;
                end else if (cnt_q == 3'd1) begin
                    cpu_di_d = tgt_ram_q ? ram_doutb : rom_douta;
                    wait_n_d = 1'b1;
                    state_d  = StHold;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StHold: begin
                if (hold_io_q ? cpu_iorq_n : !(mem_rd || mem_wr)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tgt_ram_q   <= 1'b0;
            hold_io_q   <= 1'b0;
            cpu_di_q    <= 8'hFF;
            wait_n_q    <= 1'b1;
            rom_addra_q <= '0;
            rom_ena_q   <= 1'b0;
            ram_addra_q <= '0;
            ram_dina_q  <= '0;
            ram_ena_q   <= 1'b0;
            ram_wea_q   <= 1'b0;
            ram_addrb_q <= '0;
            ram_enb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_ram_q   <= tgt_ram_d;
            hold_io_q   <= hold_io_d;
            cpu_di_q    <= cpu_di_d;
            wait_n_q    <= wait_n_d;
            rom_addra_q <= rom_addra_d;
            rom_ena_q   <= rom_ena_d;
            ram_addra_q <= ram_addra_d;
            ram_dina_q  <= ram_dina_d;
            ram_ena_q   <= ram_ena_d;
            ram_wea_q   <= ram_wea_d;
            ram_addrb_q <= ram_addrb_d;
            ram_enb_q   <= ram_enb_d;
        end
    end

`ifdef Z80_MEM_BRIDGE_IM2_EN
    // Interrupt vector, enable and pending flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vec_q     <= 8'h00;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            vblank_q  <= vblank;
        end
    end
`endif

    assign cpu_di     = cpu_di_q;
    assign cpu_wait_n = wait_n_q;
    assign rom_addra  = rom_addra_q;
    assign rom_ena    = rom_ena_q;
    assign ram_addra  = ram_addra_q;
    assign ram_dina   = ram_dina_q;
    assign ram_ena    = ram_ena_q;
    assign ram_wea    = ram_wea_q;
    assign ram_addrb  = ram_addrb_q;
    assign ram_enb    = ram_enb_q;

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Directed bench for z80_mem_bridge with block-RAM models and a read-data scoreboard.
module tb_z80_mem_bridge;

    localparam int unsigned WaitCycles = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_A;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic [7:0]  cpu_di;
    logic        cpu_wait_n, cpu_int_n;
    logic        vblank;
    logic [13:0] rom_addra;
    logic        rom_ena;
    logic [7:0]  rom_douta;
    logic [11:0] ram_addra;
    logic [7:0]  ram_dina;
    logic        ram_ena, ram_wea;
    logic [11:0] ram_addrb;
    logic        ram_enb;
    logic [7:0]  ram_doutb;

    logic [7:0] rom_mem [16384];
    logic [7:0] ram_mem [4096];
    logic [7:0] sb_q [$];

    int checks = 0;
    int errors = 0;
    int rom_pulses = 0;
    int ramrd_pulses = 0;
    int ramwr_pulses = 0;

    always #5 clk = ~clk;

    z80_mem_bridge #(
        .WAIT_CYCLES(WaitCycles),
        .ROM_AW     (14),
        .RAM_AW     (12)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_A     (cpu_A),
        .cpu_dout  (cpu_dout),
        .cpu_mreq_n(cpu_mreq_n),
        .cpu_iorq_n(cpu_iorq_n),
        .cpu_rd_n  (cpu_rd_n),
        .cpu_wr_n  (cpu_wr_n),
        .cpu_m1_n  (cpu_m1_n),
        .cpu_di    (cpu_di),
        .cpu_wait_n(cpu_wait_n),
        .cpu_int_n (cpu_int_n),
        .vblank    (vblank),
        .rom_addra (rom_addra),
        .rom_ena   (rom_ena),
        .rom_douta (rom_douta),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_enb   (ram_enb),
        .ram_doutb (ram_doutb)
    );

    // Block-RAM models, one cycle read latency.
    always @(posedge clk) begin
        if (rom_ena) rom_douta <= rom_mem[rom_addra];
        if (ram_enb) ram_doutb <= ram_mem[ram_addrb];
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
    end

    // Enable pulse counters.
    always @(posedge clk) begin
        if (rom_ena) rom_pulses <= rom_pulses + 1;
        if (ram_enb) ramrd_pulses <= ramrd_pulses + 1;
        if (ram_ena) ramwr_pulses <= ramwr_pulses + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_bus();
        @(posedge clk);
        #1;
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_m1_n   = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Full read: pushes the expected byte, waits for the stall to end, pops and compares.
    task automatic mem_read(input logic [15:0] a, input logic [7:0] exp, input int extra_hold);
        int n;
        logic [7:0] e;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        cpu_A      = a;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_wait_n && n < 20);
        e = sb_q.pop_front();
        check("read_done", 32'(cpu_wait_n), 32'd1);
        check("read_latency", 32'(n), 32'(WaitCycles + 2));
        check("read_data", 32'(cpu_di), 32'(e));
        repeat (extra_hold) @(posedge clk);
        release_bus();
    endtask

    // Drives a memory write and returns at the sampling point of cycle N+1.
    task automatic mem_write_start(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_A      = a;
        cpu_dout   = d;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_A      = {8'h00, port};
        cpu_dout   = d;
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        repeat (2) @(posedge clk);
        release_bus();
    endtask

    initial begin
        int r0, rr0, rw0;
        logic [7:0] e;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 4096; i++) ram_mem[i] = 8'h00;
        rom_mem[16'h0123] = 8'h3E;
        rom_douta  = 8'h00;
        ram_doutb  = 8'h00;
        cpu_A      = 16'h0000;
        cpu_dout   = 8'h00;
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_m1_n   = 1'b1;
        vblank     = 1'b0;
        reset_n    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        check("rst_int_n", 32'(cpu_int_n), 32'd1);
        check("rst_di", 32'(cpu_di), 32'hFF);
        check("rst_enables", 32'({rom_ena, ram_ena, ram_wea, ram_enb}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // ROM read with cycle-exact checks
        r0 = rom_pulses;
        sb_q.push_back(8'h3E);
        @(posedge clk);
        #1;
        cpu_A      = 16'h0123;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rom_ena_n1", 32'(rom_ena), 32'd1);
        check("rom_wait_n1", 32'(cpu_wait_n), 32'd0);
        @(negedge clk);
        check("rom_ena_n2", 32'(rom_ena), 32'd0);
        check("rom_wait_n2", 32'(cpu_wait_n), 32'd0);
        @(negedge clk);
        check("rom_wait_n3", 32'(cpu_wait_n), 32'd1);
        e = sb_q.pop_front();
        check("rom_di_n3", 32'(cpu_di), 32'(e));
        release_bus();
        check("rom_pulse_count", 32'(rom_pulses - r0), 32'd1);

        // RAM write then mirrored readback
        rw0 = ramwr_pulses;
        mem_write_start(16'h8010, 8'hA5);
        check("wr_ena", 32'({ram_ena, ram_wea}), 32'h3);
        check("wr_addra", 32'(ram_addra), 32'h010);
        check("wr_dina", 32'(ram_dina), 32'hA5);
        check("wr_wait_n1", 32'(cpu_wait_n), 32'd1);
        @(negedge clk);
        check("wr_pulse_end", 32'({ram_ena, ram_wea}), 32'h0);
        check("wr_wait_n2", 32'(cpu_wait_n), 32'd1);
        release_bus();
        check("wr_pulse_count", 32'(ramwr_pulses - rw0), 32'd1);
        mem_read(16'hC010, 8'hA5, 0);

        // ROM write is dropped; long-held read gives one pulse
        r0 = rom_pulses;
        rr0 = ramrd_pulses;
        rw0 = ramwr_pulses;
        mem_write_start(16'h0004, 8'h77);
        check("romwr_wait_n", 32'(cpu_wait_n), 32'd1);
        release_bus();
        check("romwr_no_pulse", 32'((rom_pulses - r0) + (ramrd_pulses - rr0) + (ramwr_pulses - rw0)),
              32'd0);
        r0 = rom_pulses;
        mem_read(16'h0200, 8'h5A, 6);
        check("hold_one_pulse", 32'(rom_pulses - r0), 32'd1);

        // Abort in WAIT leaves cpu_di unchanged
        @(posedge clk);
        #1;
        cpu_A      = 16'h0123;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_in_wait", 32'(cpu_wait_n), 32'd0);
        cpu_rd_n = 1'b1;
        @(negedge clk);
        check("abort_wait_n", 32'(cpu_wait_n), 32'd1);
        check("abort_di", 32'(cpu_di), 32'h5A);
        release_bus();
        mem_read(16'h0001, 8'h01 ^ 8'h5A, 0);

        // Reset asserted during ACCESS
        @(posedge clk);
        #1;
        cpu_A      = 16'hC010;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstacc_enb", 32'(ram_enb), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstacc_wait_n", 32'(cpu_wait_n), 32'd1);
        check("rstacc_di", 32'(cpu_di), 32'hFF);
        check("rstacc_enables", 32'({rom_ena, ram_ena, ram_wea, ram_enb}), 32'd0);
        check("rstacc_addrb", 32'(ram_addrb), 32'd0);
        reset_n = 1'b1;
        release_bus();
        mem_read(16'hC010, 8'hA5, 0);

        // Interrupt path
`ifdef Z80_MEM_BRIDGE_IM2_EN
        io_write(8'h00, 8'hCF);
        io_write(8'h01, 8'h01);
        @(negedge clk);
        check("im2_no_pending", 32'(cpu_int_n), 32'd1);
        @(posedge clk);
        #1 vblank = 1'b1;
        @(posedge clk);
        #1 vblank = 1'b0;
        @(negedge clk);
        check("im2_int_n", 32'(cpu_int_n), 32'd0);
        @(posedge clk);
        #1;
        cpu_iorq_n = 1'b0;
        cpu_m1_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("im2_ack_di", 32'(cpu_di), 32'hCF);
        check("im2_ack_int_n", 32'(cpu_int_n), 32'd1);
        release_bus();
`else
        io_write(8'h01, 8'h01);
        @(posedge clk);
        #1 vblank = 1'b1;
        @(posedge clk);
        #1 vblank = 1'b0;
        @(negedge clk);
        check("noim2_int_n", 32'(cpu_int_n), 32'd1);
        @(posedge clk);
        #1;
        cpu_iorq_n = 1'b0;
        cpu_m1_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("noim2_ack_di", 32'(cpu_di), 32'hFF);
        release_bus();
`endif
        mem_read(16'h8010, 8'hA5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
